// File: rtl/mips_pipe_hazard_ctrl.sv
// mips_pipe_hazard_ctrl
//   Pipeline sequencer for the 5-stage MIPS core. Produces per-stage load
//   enables and flushes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB from a small
//   registered FSM (RUN / MEM_WAIT / HALT / ERROR) plus the current stage
//   inputs. Handles load-use stalls, taken-branch squash, multi-cycle data
//   memory waits with a timeout, and HALT.
//
//   Optional feature: define PIPE_PERF_CNT_EN to build the saturating
//   stall/flush performance counters; otherwise both counter outputs are 0.
//
//   Control handshake: I_MEM_REQ/I_MEM_ACK form a level protocol. The MEM
//   stage holds I_MEM_REQ high while its access is outstanding; the access
//   completes in the cycle I_MEM_ACK is high. A cycle with I_MEM_REQ high and
//   I_MEM_ACK low freezes everything upstream of MEM/WB and sends a bubble
//   into WB.
module mips_pipe_hazard_ctrl #(
  parameter int REG_W       = 5,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [REG_W-1:0] I_ID_RS,
  input  logic [REG_W-1:0] I_ID_RT,
  input  logic             I_ID_USES_RT,
  input  logic             I_EX_MEMREAD,
  input  logic [REG_W-1:0] I_EX_RD,
  input  logic             I_BRANCH_TAKEN,
  input  logic             I_MEM_REQ,
  input  logic             I_MEM_ACK,
  input  logic             I_HALT,
  output logic             O_PC_EN,
  output logic             O_IF_ID_EN,
  output logic             O_ID_EX_EN,
  output logic             O_EX_MEM_EN,
  output logic             O_MEM_WB_EN,
  output logic             O_IF_ID_FLUSH,
  output logic             O_ID_EX_FLUSH,
  output logic             O_MEM_WB_BUBBLE,
  output logic [1:0]       O_STATE,
  output logic             O_HALTED,
  output logic             O_MEM_TIMEOUT,
  output logic [CNT_W-1:0] O_STALL_CNT,
  output logic [CNT_W-1:0] O_FLUSH_CNT
);

  // Wait counter only has to reach MEM_TIMEOUT-1.
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_HALT     = 2'd2,
    S_ERROR    = 2'd3
  } state_t;

  state_t            r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_halted;
  logic              r_mem_timeout;

  logic w_loaduse;
  logic w_memstall;
  logic w_active;
  logic w_freeze;
  logic w_flow;
  logic w_rule3;
  logic w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en;
  logic w_if_id_flush, w_id_ex_flush, w_bubble;

  assign w_loaduse  = I_EX_MEMREAD && (I_EX_RD != '0) &&
                      ((I_EX_RD == I_ID_RS) || (I_ID_USES_RT && (I_EX_RD == I_ID_RT)));
  assign w_memstall = I_MEM_REQ && !I_MEM_ACK;

  // RUN and MEM_WAIT are the only states that move the pipe; HALT is only
  // honoured from RUN (WB sees bubbles while waiting on memory).
  assign w_active = ((r_state == S_RUN) && !I_HALT) || (r_state == S_MEM_WAIT);
  assign w_freeze = w_active && w_memstall;
  assign w_flow   = w_active && !w_memstall;
  assign w_rule3  = w_flow && I_BRANCH_TAKEN;

  // Stage controls: freeze, branch squash, load-use bubble, or free flow.
  always_comb begin
    w_pc_en       = 1'b0;
    w_if_id_en    = 1'b0;
    w_id_ex_en    = 1'b0;
    w_ex_mem_en   = 1'b0;
    w_mem_wb_en   = 1'b0;
    w_if_id_flush = 1'b0;
    w_id_ex_flush = 1'b0;
    w_bubble      = 1'b0;
    if (w_freeze) begin
      w_mem_wb_en = 1'b1;
      w_bubble    = 1'b1;
    end else if (w_flow) begin
      if (I_BRANCH_TAKEN) begin
        // Squash wins over load-use: the stalled instruction is wrong-path.
        w_pc_en       = 1'b1;
        w_if_id_en    = 1'b1;
        w_id_ex_en    = 1'b1;
        w_ex_mem_en   = 1'b1;
        w_mem_wb_en   = 1'b1;
        w_if_id_flush = 1'b1;
        w_id_ex_flush = 1'b1;
      end else if (w_loaduse) begin
        // Hold PC and IF/ID one cycle, insert NOP into ID/EX.
        w_id_ex_flush = 1'b1;
        w_ex_mem_en   = 1'b1;
        w_mem_wb_en   = 1'b1;
      end else begin
        w_pc_en     = 1'b1;
        w_if_id_en  = 1'b1;
        w_id_ex_en  = 1'b1;
        w_ex_mem_en = 1'b1;
        w_mem_wb_en = 1'b1;
      end
    end
  end

  // Everything is quiet while RESET is held.
  assign O_PC_EN         = !RESET && w_pc_en;
  assign O_IF_ID_EN      = !RESET && w_if_id_en;
  assign O_ID_EX_EN      = !RESET && w_id_ex_en;
  assign O_EX_MEM_EN     = !RESET && w_ex_mem_en;
  assign O_MEM_WB_EN     = !RESET && w_mem_wb_en;
  assign O_IF_ID_FLUSH   = !RESET && w_if_id_flush;
  assign O_ID_EX_FLUSH   = !RESET && w_id_ex_flush;
  assign O_MEM_WB_BUBBLE = !RESET && w_bubble;

  assign O_STATE       = r_state;
  assign O_HALTED      = r_halted;
  assign O_MEM_TIMEOUT = r_mem_timeout;

  // Sequencer FSM with wait counter and sticky halt/timeout flags.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state       <= S_RUN;
      r_wait_cnt    <= '0;
      r_halted      <= 1'b0;
      r_mem_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (I_HALT) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else if (w_memstall) begin
            r_state    <= S_MEM_WAIT;
            r_wait_cnt <= '0;
          end
        end
        S_MEM_WAIT: begin
          if (!w_memstall) begin
            // Ack wins over a timeout reached in the same cycle.
            r_state    <= S_RUN;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt == WAIT_LAST) begin
            r_state       <= S_ERROR;
            r_mem_timeout <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_stall_inc;

  assign w_stall_inc = ((r_state == S_RUN) || (r_state == S_MEM_WAIT)) && !w_pc_en;

  // Saturating stall and branch-flush counters.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_inc && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_rule3 && (r_flush_cnt != '1))     r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign O_STALL_CNT = r_stall_cnt;
  assign O_FLUSH_CNT = r_flush_cnt;
`else
  assign O_STALL_CNT = '0;
  assign O_FLUSH_CNT = '0;
`endif

endmodule

// File: tb/tb_mips_pipe_hazard_ctrl.sv
// tb_mips_pipe_hazard_ctrl
//   Directed scenarios followed by randomized traffic, all checked against a
//   behavioural model of the sequencing rules kept in this file.
module tb_mips_pipe_hazard_ctrl;
  localparam int REG_W = 5;
  localparam int TO    = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  logic [REG_W-1:0] I_ID_RS, I_ID_RT, I_EX_RD;
  logic I_ID_USES_RT, I_EX_MEMREAD, I_BRANCH_TAKEN, I_MEM_REQ, I_MEM_ACK, I_HALT;
  logic O_PC_EN, O_IF_ID_EN, O_ID_EX_EN, O_EX_MEM_EN, O_MEM_WB_EN;
  logic O_IF_ID_FLUSH, O_ID_EX_FLUSH, O_MEM_WB_BUBBLE, O_HALTED, O_MEM_TIMEOUT;
  logic [1:0] O_STATE;
  logic [CNT_W-1:0] O_STALL_CNT, O_FLUSH_CNT;

  mips_pipe_hazard_ctrl #(.REG_W(REG_W), .MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET(RESET),
    .I_ID_RS(I_ID_RS), .I_ID_RT(I_ID_RT), .I_ID_USES_RT(I_ID_USES_RT),
    .I_EX_MEMREAD(I_EX_MEMREAD), .I_EX_RD(I_EX_RD), .I_BRANCH_TAKEN(I_BRANCH_TAKEN),
    .I_MEM_REQ(I_MEM_REQ), .I_MEM_ACK(I_MEM_ACK), .I_HALT(I_HALT),
    .O_PC_EN(O_PC_EN), .O_IF_ID_EN(O_IF_ID_EN), .O_ID_EX_EN(O_ID_EX_EN),
    .O_EX_MEM_EN(O_EX_MEM_EN), .O_MEM_WB_EN(O_MEM_WB_EN),
    .O_IF_ID_FLUSH(O_IF_ID_FLUSH), .O_ID_EX_FLUSH(O_ID_EX_FLUSH),
    .O_MEM_WB_BUBBLE(O_MEM_WB_BUBBLE), .O_STATE(O_STATE), .O_HALTED(O_HALTED),
    .O_MEM_TIMEOUT(O_MEM_TIMEOUT), .O_STALL_CNT(O_STALL_CNT), .O_FLUSH_CNT(O_FLUSH_CNT)
  );

  // ---------------- scoreboard counters ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Mode: 0 RUN, 1 MEM_WAIT, 2 HALT, 3 ERROR.
  int m_mode, m_waited, m_stall, m_flush;
  bit m_halted, m_tmo, m_squash;
  logic [7:0] m_ctrl; // {pc,if_id,id_ex,ex_mem,mem_wb,if_id_fl,id_ex_fl,bubble}

  task automatic model_reset();
    m_mode = 0; m_waited = 0; m_stall = 0; m_flush = 0;
    m_halted = 0; m_tmo = 0;
  endtask

  task automatic model_outputs();
    bit hazard, waiting;
    hazard  = I_EX_MEMREAD && (I_EX_RD != 0) &&
              (I_EX_RD == I_ID_RS || (I_ID_USES_RT && I_EX_RD == I_ID_RT));
    waiting = I_MEM_REQ && !I_MEM_ACK;
    m_ctrl   = 8'b0000_0000;
    m_squash = 0;
    if (RESET || m_mode >= 2 || (m_mode == 0 && I_HALT)) m_ctrl = 8'b0000_0000;
    else if (waiting)        m_ctrl = 8'b0000_1001;
    else if (I_BRANCH_TAKEN) begin m_ctrl = 8'b1111_1110; m_squash = 1; end
    else if (hazard)         m_ctrl = 8'b0001_1010;
    else                     m_ctrl = 8'b1111_1000;
  endtask

  task automatic model_step();
    bit waiting;
    waiting = I_MEM_REQ && !I_MEM_ACK;
    if (m_mode <= 1 && !m_ctrl[7] && m_stall < CMAX) m_stall++;
    if (m_squash && m_flush < CMAX) m_flush++;
    if (m_mode == 0) begin
      if (I_HALT) begin m_mode = 2; m_halted = 1; end
      else if (waiting) begin m_mode = 1; m_waited = 0; end
    end else if (m_mode == 1) begin
      if (!waiting) m_mode = 0;
      else if (m_waited + 1 == TO) begin m_mode = 3; m_tmo = 1; end
      else m_waited++;
    end
  endtask

  // One clock: compare at the falling edge, advance model, step past rising edge.
  task automatic cycle();
    @(negedge CLK);
    if (RESET) model_reset();
    model_outputs();
    chk("ctrl", 32'({O_PC_EN, O_IF_ID_EN, O_ID_EX_EN, O_EX_MEM_EN, O_MEM_WB_EN,
                     O_IF_ID_FLUSH, O_ID_EX_FLUSH, O_MEM_WB_BUBBLE}), 32'(m_ctrl));
    chk("state", 32'(O_STATE), 32'(m_mode));
    chk("halted", 32'(O_HALTED), 32'(m_halted));
    chk("mem_timeout", 32'(O_MEM_TIMEOUT), 32'(m_tmo));
`ifdef PIPE_PERF_CNT_EN
    chk("stall_cnt", 32'(O_STALL_CNT), 32'(m_stall));
    chk("flush_cnt", 32'(O_FLUSH_CNT), 32'(m_flush));
`else
    chk("stall_cnt", 32'(O_STALL_CNT), 32'd0);
    chk("flush_cnt", 32'(O_FLUSH_CNT), 32'd0);
`endif
    if (!RESET) model_step();
    @(posedge CLK);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    I_ID_RS = '0; I_ID_RT = '0; I_EX_RD = '0; I_ID_USES_RT = 0; I_EX_MEMREAD = 0;
    I_BRANCH_TAKEN = 0; I_MEM_REQ = 0; I_MEM_ACK = 0; I_HALT = 0;
  endtask

  task automatic pulse_reset();
    RESET = 1;
    cycle();
    RESET = 0;
  endtask

  task automatic set_hazard(input logic [REG_W-1:0] rd, input logic [REG_W-1:0] rs,
                            input logic [REG_W-1:0] rt, input logic uses_rt);
    I_EX_MEMREAD = 1; I_EX_RD = rd; I_ID_RS = rs; I_ID_RT = rt; I_ID_USES_RT = uses_rt;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    RESET = 1;
    model_reset();
    #1;
    // reset state, asynchronous (before any clock edge)
    chk("reset_state", 32'(O_STATE), 32'd0);
    chk("reset_pc_en", 32'(O_PC_EN), 32'd0);
    cycle();
    cycle();
    RESET = 0;
    cycle();

    // T1 load-use on rs
    set_hazard(5'd8, 5'd8, 5'd3, 1'b0);
    cycle();
    chk("t1_pc_en", 32'(O_PC_EN), 32'd0);
    chk("t1_id_ex_flush", 32'(O_ID_EX_FLUSH), 32'd1);
    // load-use on rt
    set_hazard(5'd9, 5'd1, 5'd9, 1'b1);
    cycle();
    // T2 rd=0, and rt match without USES_RT
    set_hazard(5'd0, 5'd0, 5'd0, 1'b1);
    cycle();
    chk("t2_rd0_pc_en", 32'(O_PC_EN), 32'd1);
    set_hazard(5'd7, 5'd1, 5'd7, 1'b0);
    cycle();
    chk("t2_rt_nouse_if_id_en", 32'(O_IF_ID_EN), 32'd1);

    // T3 branch with load-use
    set_hazard(5'd8, 5'd8, 5'd3, 1'b0);
    I_BRANCH_TAKEN = 1;
    cycle();
    chk("t3_pc_en", 32'(O_PC_EN), 32'd1);
    chk("t3_if_id_flush", 32'(O_IF_ID_FLUSH), 32'd1);
    idle_inputs();
    cycle();

    // T4 memory wait, ack on 4th cycle
    I_MEM_REQ = 1;
    for (int i = 0; i < 3; i++) cycle();
    chk("t4_state_wait", 32'(O_STATE), 32'd1);
    I_MEM_ACK = 1;
    cycle();
    chk("t4_state_run", 32'(O_STATE), 32'd0);
    idle_inputs();
    cycle();

    // T5 timeout: one entry cycle plus TO waiting cycles
    I_MEM_REQ = 1;
    for (int i = 0; i < TO + 1; i++) cycle();
    chk("t5_state_error", 32'(O_STATE), 32'd3);
    chk("t5_timeout", 32'(O_MEM_TIMEOUT), 32'd1);
    I_MEM_ACK = 1; I_HALT = 1;
    cycle();
    cycle();

    // T6 reset mid-wait, then halt
    idle_inputs();
    pulse_reset();
    I_MEM_REQ = 1;
    cycle();
    cycle();
    I_HALT = 1; // ignored while waiting
    cycle();
    pulse_reset();
    chk("t6_state_run", 32'(O_STATE), 32'd0);
    idle_inputs();
    I_HALT = 1;
    cycle();
    chk("t6_state_halt", 32'(O_STATE), 32'd2);
    chk("t6_halted", 32'(O_HALTED), 32'd1);
    I_HALT = 0;
    cycle();
    pulse_reset();

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      I_ID_RS        = 5'($urandom_range(0, 3));
      I_ID_RT        = 5'($urandom_range(0, 3));
      I_EX_RD        = 5'($urandom_range(0, 3));
      I_ID_USES_RT   = 1'($urandom_range(0, 1));
      I_EX_MEMREAD   = ($urandom_range(0, 2) != 0);
      I_BRANCH_TAKEN = ($urandom_range(0, 4) == 0);
      I_MEM_REQ      = ($urandom_range(0, 2) == 0);
      I_MEM_ACK      = ($urandom_range(0, 3) == 0);
      I_HALT         = ($urandom_range(0, 60) == 0);
      RESET          = (m_mode >= 2) && ($urandom_range(0, 5) == 0);
      cycle();
      RESET = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Overall time bound.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end
endmodule
